// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit for the MEM stage. Decodes the memory controls carried
//   down from ID, rejects misaligned accesses, and runs each aligned access
//   as one single-beat bus transaction (IDLE -> BUSY -> DONE). Byte enables
//   and write data are formed for stores. Returned words are formatted for
//   loads, including the unaligned LWL/LWR merges.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   mem_read_flag       : instruction is a load
//   mem_write_flag      : instruction is a store
//   mem_sign_ext_flag   : sign-extend byte/half loads
//   mem_sel[3:0]        : access size (0001 byte, 0011 half, 1111 word)
//   mem_write_data[31:0]: store data / rt value merged by LWL/LWR
//   mem_op[5:0]         : primary opcode (selects LWL/LWR/SWL/SWR)
//   address[31:0]       : effective address from EX
//   bus_ready           : bus transaction complete
//   bus_rdata[31:0]     : little-endian read word
//   bus_en              : bus request, held through BUSY
//   bus_we[3:0]         : byte write enables (zero for loads)
//   bus_addr[31:0]      : word-aligned bus address
//   bus_wdata[31:0]     : lane-aligned write data
//   read_data[31:0]     : formatted load result for WB
//   stall_request       : hold the pipeline while an access is in flight
//   bus_error           : one-cycle pulse on bus timeout
//   addr_error_load     : misaligned load (combinational, IDLE only)
//   addr_error_store    : misaligned store (combinational, IDLE only)
module mem_access_unit #(
    parameter int BUS_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic [5:0]  mem_op,
    input  logic [31:0] address,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        bus_en,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [31:0] read_data,
    output logic        stall_request,
    output logic        bus_error,
    output logic        addr_error_load,
    output logic        addr_error_store
);

    // Shared MIPS primary opcodes for the unaligned word accesses
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SWL = 6'h2A;
    localparam logic [5:0] OP_SWR = 6'h2E;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int             CNT_W    = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    logic [1:0]       r_state;
    logic             r_bus_en;
    logic [3:0]       r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [31:0]      r_read_data;
    logic             r_bus_error;
    logic [CNT_W-1:0] r_cnt;

    // Access context captured at launch, used to format the returned word
    logic [1:0]  r_n;
    logic [1:0]  r_size;
    logic [5:0]  r_op;
    logic        r_sign;
    logic        r_is_read;
    logic [31:0] r_rt;

    logic [1:0]  w_size;
    logic        w_unaligned_op;
    logic        w_misalign;
    logic        w_access;
    logic        w_is_write;
    logic        w_start;
    logic [35:0] w_store;

    // Load formatting: lane select plus extension, or the LWL/LWR merge with rt
    function automatic logic [31:0] fmt_load(input logic [5:0]  op,
                                             input logic [1:0]  sz,
                                             input logic        sgn,
                                             input logic [1:0]  n,
                                             input logic [31:0] m,
                                             input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(m >> {n, 3'b000});
        h = n[1] ? m[31:16] : m[15:0];
        if (op == OP_LWL)
            // mask shift reaches 32 for n=3, leaving no rt bytes
            return (m << {~n, 3'b000}) |
                   (rt & (32'hFFFF_FFFF >> ({1'b0, n, 3'b000} + 6'd8)));
        if (op == OP_LWR)
            return (m >> {n, 3'b000}) | (rt & ~(32'hFFFF_FFFF >> {n, 3'b000}));
        case (sz)
            SZ_BYTE: return sgn ? {{24{b[7]}}, b} : {24'd0, b};
            SZ_HALF: return sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: return m;
        endcase
    endfunction

    // Store formatting: returns {byte enables, lane-aligned data}
    function automatic logic [35:0] fmt_store(input logic [5:0]  op,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  n,
                                              input logic [31:0] wd);
        if (op == OP_SWL)
            return {4'b1111 >> ~n, wd >> {~n, 3'b000}};
        if (op == OP_SWR)
            return {4'b1111 << n, wd << {n, 3'b000}};
        case (sz)
            SZ_BYTE: return {4'b0001 << n, {4{wd[7:0]}}};
            SZ_HALF: return {n[1] ? 4'b1100 : 4'b0011, {2{wd[15:0]}}};
            default: return {4'b1111, wd};
        endcase
    endfunction

    assign w_size = (mem_sel == 4'b0001) ? SZ_BYTE :
                    (mem_sel == 4'b0011) ? SZ_HALF : SZ_WORD;

    assign w_unaligned_op = (mem_op == OP_LWL) || (mem_op == OP_LWR) ||
                            (mem_op == OP_SWL) || (mem_op == OP_SWR);

    assign w_misalign = !w_unaligned_op &&
                        (((w_size == SZ_HALF) && address[0]) ||
                         ((w_size == SZ_WORD) && (address[1:0] != 2'b00)));

    assign w_access   = (mem_read_flag || mem_write_flag) && (r_state == ST_IDLE);
    assign w_is_write = mem_write_flag && !mem_read_flag;
    assign w_start    = w_access && !w_misalign;
    assign w_store    = fmt_store(mem_op, w_size, address[1:0], mem_write_data);

    // Errors and stall are combinational so the pipeline reacts in the same cycle
    assign addr_error_load  = !rst && w_access && w_misalign && !w_is_write;
    assign addr_error_store = !rst && w_access && w_misalign &&  w_is_write;
    assign stall_request    = !rst && (w_start || (r_state == ST_BUSY));

    assign bus_en    = r_bus_en;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign read_data = r_read_data;
    assign bus_error = r_bus_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bus_en    <= 1'b0;
            r_bus_we    <= 4'b0000;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_read_data <= 32'd0;
            r_bus_error <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_bus_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_BUSY;
                        r_bus_en    <= 1'b1;
                        r_bus_addr  <= {address[31:2], 2'b00};
                        r_bus_we    <= w_is_write ? w_store[35:32] : 4'b0000;
                        r_bus_wdata <= w_is_write ? w_store[31:0] : 32'd0;
                        r_cnt       <= '0;
                    end
                end
                ST_BUSY: begin
                    // A completing bus wins over a timeout in the same cycle
                    if (bus_ready) begin
                        r_state  <= ST_DONE;
                        r_bus_en <= 1'b0;
                        r_cnt    <= '0;
                        if (r_is_read)
                            r_read_data <= fmt_load(r_op, r_size, r_sign, r_n, bus_rdata, r_rt);
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= ST_DONE;
                        r_bus_en    <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_cnt       <= '0;
                        if (r_is_read)
                            r_read_data <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_n       <= address[1:0];
            r_size    <= w_size;
            r_op      <= mem_op;
            r_sign    <= mem_sign_ext_flag;
            r_is_read <= !w_is_write;
            r_rt      <= mem_write_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TMO = 4;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SWL = 6'h2A;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SWR = 6'h2E;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic [5:0]  mem_op;
    logic [31:0] address;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_en;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr, bus_wdata, read_data;
    logic        stall_request, bus_error, addr_error_load, addr_error_store;

    int checks = 0;
    int errors = 0;

    // kind: 0 bus transaction, 1 misaligned load, 2 misaligned store
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] rd;
        logic        berr;
        int          stall;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rd;

    exp_t        mon_e;
    logic        prev_en;
    int          stall_cnt;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_we;

    always #5 clk = ~clk;

    mem_access_unit #(.BUS_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_flag     (mem_read_flag),
        .mem_write_flag    (mem_write_flag),
        .mem_sign_ext_flag (mem_sign_ext_flag),
        .mem_sel           (mem_sel),
        .mem_write_data    (mem_write_data),
        .mem_op            (mem_op),
        .address           (address),
        .bus_ready         (bus_ready),
        .bus_rdata         (bus_rdata),
        .bus_en            (bus_en),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .read_data         (read_data),
        .stall_request     (stall_request),
        .bus_error         (bus_error),
        .addr_error_load   (addr_error_load),
        .addr_error_store  (addr_error_store)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
    endfunction

    function automatic logic [3:0] sel_of(input logic [5:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB}) return 4'b0001;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input int n);
        if (op inside {OP_LH, OP_LHU, OP_SH}) return (n % 2) != 0;
        if (op inside {OP_LW, OP_SW}) return n != 0;
        return 1'b0;
    endfunction

    // Byte-lane view of memory: result built one byte at a time
    function automatic logic [31:0] mdl_load(input logic [5:0] op, input int n,
                                             input logic [31:0] m, input logic [31:0] rt,
                                             input logic sgn);
        logic [7:0]  mb[4];
        logic [7:0]  rb[4];
        logic [31:0] res;
        logic [15:0] hw;
        for (int k = 0; k < 4; k++) begin
            mb[k] = m[8*k +: 8];
            rb[k] = rt[8*k +: 8];
        end
        res = 32'd0;
        case (op)
            OP_LB, OP_LBU: res = sgn ? {{24{mb[n][7]}}, mb[n]} : {24'd0, mb[n]};
            OP_LH, OP_LHU: begin
                hw  = {mb[n+1], mb[n]};
                res = sgn ? {{16{hw[15]}}, hw} : {16'd0, hw};
            end
            OP_LWL: for (int k = 0; k < 4; k++)
                res[8*k +: 8] = (k >= 3 - n) ? mb[k - (3 - n)] : rb[k];
            OP_LWR: for (int k = 0; k < 4; k++)
                res[8*k +: 8] = (k <= 3 - n) ? mb[k + n] : rb[k];
            default: res = m;
        endcase
        return res;
    endfunction

    function automatic void mdl_store(input logic [5:0] op, input int n, input logic [31:0] wd,
                                      output logic [3:0] we, output logic [31:0] data);
        logic [7:0] wb[4];
        for (int k = 0; k < 4; k++) wb[k] = wd[8*k +: 8];
        we   = 4'b0000;
        data = 32'd0;
        case (op)
            OP_SB: begin
                we[n] = 1'b1;
                for (int k = 0; k < 4; k++) data[8*k +: 8] = wb[0];
            end
            OP_SH: begin
                we[n] = 1'b1;
                we[n+1] = 1'b1;
                for (int k = 0; k < 4; k++) data[8*k +: 8] = wb[k % 2];
            end
            OP_SWL: for (int k = 0; k < 4; k++)
                if (k <= n) begin
                    we[k] = 1'b1;
                    data[8*k +: 8] = wb[k + 3 - n];
                end
            OP_SWR: for (int k = 0; k < 4; k++)
                if (k >= n) begin
                    we[k] = 1'b1;
                    data[8*k +: 8] = wb[k - n];
                end
            default: begin
                we   = 4'b1111;
                data = wd;
            end
        endcase
    endfunction

    task automatic idle_inputs();
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        bus_ready      = 1'b0;
    endtask

    // Bus responder: waits for bus_en, raises ready in BUSY cycle 'delay'
    task automatic run_bus(input int delay, input logic [31:0] rdata);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus_en && guard < 3);
        check("bus_start", 32'(bus_en), 32'd1);
        for (int i = 0; bus_en && i < 64; i++) begin
            bus_ready = (i == delay);
            bus_rdata = (i == delay) ? rdata : $urandom;
            @(negedge clk);
        end
        bus_ready = 1'b0;
    endtask

    task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int delay);
        exp_t e;
        int   n;
        logic ld;
        logic sgn;
        int   busy;
        n   = int'(addr[1:0]);
        ld  = is_load(op);
        sgn = (op == OP_LB || op == OP_LH) ? 1'b1 :
              (op == OP_LBU || op == OP_LHU) ? 1'b0 : 1'($urandom);
        mem_op            = op;
        mem_sel           = sel_of(op);
        mem_sign_ext_flag = sgn;
        mem_read_flag     = ld;
        mem_write_flag    = !ld;
        address           = addr;
        mem_write_data    = wd;
        e = '{kind: 0, addr: 32'd0, we: 4'd0, wdata: 32'd0, wr: 1'b0, rd: 32'd0, berr: 1'b0, stall: 0};
        if (misaligned(op, n)) begin
            e.kind = ld ? 1 : 2;
            sb.push_back(e);
            @(negedge clk);
            @(posedge clk); #1;
            idle_inputs();
        end else begin
            e.addr = {addr[31:2], 2'b00};
            e.wr   = !ld;
            if (!ld) mdl_store(op, n, wd, e.we, e.wdata);
            if (delay < TMO) begin
                busy = delay + 1;
                if (ld) model_rd = mdl_load(op, n, rdata, wd, sgn);
            end else begin
                busy   = TMO;
                e.berr = 1'b1;
                if (ld) model_rd = 32'd0;
            end
            e.rd    = model_rd;
            e.stall = 1 + busy;
            sb.push_back(e);
            run_bus(delay, rdata);
            @(posedge clk); #1;
            idle_inputs();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_en   = 1'b0;
            stall_cnt = 0;
        end else begin
            if (stall_request) stall_cnt++;
            if (addr_error_load || addr_error_store) begin
                if (sb.size() == 0) begin
                    check("aerr_unexpected", 32'({addr_error_load, addr_error_store}), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("aerr_load", 32'(addr_error_load), 32'(mon_e.kind == 1));
                    check("aerr_store", 32'(addr_error_store), 32'(mon_e.kind == 2));
                    check("aerr_stall", 32'(stall_request), 32'd0);
                    check("aerr_bus_en", 32'(bus_en), 32'd0);
                    check("aerr_bus_error", 32'(bus_error), 32'd0);
                end
                stall_cnt = 0;
            end
            if (bus_en && !prev_en) begin
                cap_addr  = bus_addr;
                cap_we    = bus_we;
                cap_wdata = bus_wdata;
                if (sb.size() == 0) begin
                    check("bus_unexpected", 32'(bus_en), 32'd0);
                end else begin
                    check("bus_kind", 32'(sb[0].kind), 32'd0);
                    check("bus_addr", bus_addr, sb[0].addr);
                    check("bus_we", 32'(bus_we), 32'(sb[0].we));
                    if (sb[0].wr) check("bus_wdata", bus_wdata, sb[0].wdata);
                end
            end else if (bus_en) begin
                check("busy_stable_addr", bus_addr, cap_addr);
                check("busy_stable_we", 32'(bus_we), 32'(cap_we));
                check("busy_stable_wdata", bus_wdata, cap_wdata);
                check("busy_stall", 32'(stall_request), 32'd1);
            end else if (prev_en) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_read_data", read_data, mon_e.rd);
                    check("done_bus_error", 32'(bus_error), 32'(mon_e.berr));
                    check("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
                    check("done_stall", 32'(stall_request), 32'd0);
                    check("done_aerr", 32'({addr_error_load, addr_error_store}), 32'd0);
                end
                stall_cnt = 0;
            end else if (bus_error) begin
                check("bus_error_spurious", 32'(bus_error), 32'd0);
            end
            prev_en = bus_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [5:0] ops[12];
        ops = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
                OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
        model_rd = 32'd0;
        rst = 1'b1;
        bus_ready = 1'b0;
        bus_rdata = 32'd0;
        mem_sign_ext_flag = 1'b0;
        mem_write_data = 32'd0;
        // Misaligned load presented during reset must not flag
        mem_op = OP_LW; mem_sel = 4'b1111; mem_read_flag = 1'b1; mem_write_flag = 1'b0;
        address = 32'h3001;
        @(negedge clk);
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_aerr_load", 32'(addr_error_load), 32'd0);
        address = 32'h3000;
        @(negedge clk);
        check("rst_stall", 32'(stall_request), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;

        do_op(OP_LB,  32'h0000_1003, 32'h0,         32'h8011_2233, 0);
        do_op(OP_SH,  32'h0000_2002, 32'h0000_ABCD, 32'h0,         3);
        do_op(OP_LW,  32'h0000_3001, 32'h0,         32'h0,         0);
        do_op(OP_LW,  32'h0000_5000, 32'h0,         32'h1234_5678, 99);
        do_op(OP_LWL, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 1);
        do_op(OP_LWR, 32'h0000_4002, 32'h1122_3344, 32'hAABB_CCDD, 0);

        // Reset in the second BUSY cycle abandons the transaction
        e = '{kind: 0, addr: 32'h7000, we: 4'd0, wdata: 32'd0, wr: 1'b0, rd: 32'd0, berr: 1'b0, stall: 0};
        sb.push_back(e);
        mem_op = OP_LW; mem_sel = 4'b1111; mem_read_flag = 1'b1; mem_write_flag = 1'b0;
        address = 32'h7000;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_bus_en", 32'(bus_en), 32'd0);
        check("midrst_read_data", read_data, 32'd0);
        check("midrst_bus_we", 32'(bus_we), 32'd0);
        check("midrst_bus_addr", bus_addr, 32'd0);
        rst = 1'b0;
        idle_inputs();
        model_rd = 32'd0;
        @(posedge clk); #1;
        check("post_rst_stall", 32'(stall_request), 32'd0);

        do_op(OP_SWR, 32'h0000_6003, 32'h1234_5678, 32'h0, 2);

        for (int i = 0; i < 60; i++)
            do_op(ops[$urandom_range(0, 11)], $urandom, $urandom, $urandom, $urandom_range(0, 5));

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
